fetch_queue: RTL and testbench

- Instruction-fetch stage directly upstream of decode.
- Issues 32-bit instruction reads to the instruction-memory port and tracks in-order responses with their PCs.
- Buffers fetched instructions in a small queue and presents one registered {pc, instruction} pair per cycle to decode.
- Honours decode's stall and flushes on a branch redirect, including discarding stale in-flight responses.

---
 rtl/fetch_queue_if.sv | 28 ++
 rtl/fetch_queue.sv | 159 +++++++++++++++
 tb/tb_fetch_queue.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Bundle of the fetch stage's decode-side and instruction-memory-side signals.
// The master modport is the fetch stage; the slave modport is the surrounding
// environment (decode plus instruction memory).
interface fetch_queue_if #(
  parameter int BUS_DATA_WIDTH = 64
);
  logic                      inStall;
  logic                      inRedirect;
  logic [BUS_DATA_WIDTH-1:0] inRedirectPc;
  logic                      outReqValid;
  logic [BUS_DATA_WIDTH-1:0] outReqAddr;
  logic                      inReqReady;
  logic                      inRespValid;
  logic [31:0]               inRespData;
  logic [BUS_DATA_WIDTH-1:0] outPc;
  logic [31:0]               outIns;
  logic                      outValid;

  modport master (
    input  inStall, inRedirect, inRedirectPc, inReqReady, inRespValid, inRespData,
    output outReqValid, outReqAddr, outPc, outIns, outValid
  );

  modport slave (
    output inStall, inRedirect, inRedirectPc, inReqReady, inRespValid, inRespData,
    input  outReqValid, outReqAddr, outPc, outIns, outValid
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: issues in-order 32-bit reads, pairs each response
// with its PC, buffers them in a small circular queue and hands one registered
// {pc, instruction} pair per cycle to decode. A redirect flushes everything and
// turns outstanding requests into "stale" responses that are silently dropped.
module fetch_queue #(
  parameter int                        BUS_DATA_WIDTH = 64,
  parameter logic [BUS_DATA_WIDTH-1:0] RESET_PC       = '0,
  parameter int                        QUEUE_DEPTH    = 4
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master bus
);
  localparam int          W   = BUS_DATA_WIDTH;
  localparam int          PW  = $clog2(QUEUE_DEPTH);
  localparam int          CW  = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {RUN, DRAIN} state_e;

  typedef struct packed {
    logic [W-1:0] pc;
    logic [31:0]  ins;
  } entry_t;

  state_e        state_q, state_d;
  logic [W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [W-1:0]  resp_pc_q, resp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] live_q, live_d;
  logic [CW-1:0] stale_q, stale_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [W-1:0]  out_pc_q, out_pc_d;
  logic [31:0]   out_ins_q, out_ins_d;
  logic          out_valid_q, out_valid_d;
  entry_t        queue_q [QUEUE_DEPTH];

  logic req_valid, accept, push, drop, pop;

  // Request credit: room in the queue for every live request, and never more
  // than QUEUE_DEPTH responses (live or stale) outstanding at the memory.
  always_comb begin
    req_valid = !reset && !bus.inRedirect
             && ((CW+1)'(count_q) + (CW+1)'(live_q) < (CW+1)'(QUEUE_DEPTH))
             && ((CW+1)'(live_q) + (CW+1)'(stale_q) < (CW+1)'(QUEUE_DEPTH));
    accept    = req_valid && bus.inReqReady;
    push      = bus.inRespValid && !bus.inRedirect && (state_q == RUN);
    drop      = bus.inRespValid && !bus.inRedirect && (state_q == DRAIN);
    pop       = !bus.inStall && !bus.inRedirect && (count_q != '0);
  end

  assign bus.outReqValid = req_valid;
  assign bus.outReqAddr  = fetch_pc_q;
  assign bus.outPc       = out_pc_q;
  assign bus.outIns      = out_ins_q;
  assign bus.outValid    = out_valid_q;

  // Datapath next-state: PCs, queue pointers, credit counters, output pair.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    fetch_pc_d  = fetch_pc_q;
    resp_pc_d   = resp_pc_q;
    count_d     = count_q;
    live_d      = live_q;
    stale_d     = stale_q;
    head_d      = head_q;
    tail_d      = tail_q;
    out_pc_d    = out_pc_q;
    out_ins_d   = out_ins_q;
    out_valid_d = out_valid_q;

    if (bus.inRedirect) begin
      // Everything requested so far becomes stale; a response arriving this
      // cycle retires one of them immediately.
      fetch_pc_d  = bus.inRedirectPc;
      resp_pc_d   = bus.inRedirectPc;
      count_d     = '0;
      head_d      = '0;
      tail_d      = '0;
      live_d      = '0;
      stale_d     = stale_q + live_q - CW'(bus.inRespValid);
      out_ins_d   = NOP;
      out_valid_d = 1'b0;
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + W'(4);
      if (push) begin
        resp_pc_d = resp_pc_q + W'(4);
        tail_d    = tail_q + PW'(1);
      end
      if (pop) head_d = head_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      live_d  = live_q + CW'(accept) - CW'(push);
      stale_d = stale_q - CW'(drop);

      // Output register only reads the queue head; a same-cycle push is not
      // forwarded, so a fresh entry reaches decode one cycle after landing.
      if (!bus.inStall) begin
        if (count_q != '0) begin
          out_pc_d    = queue_q[head_q].pc;
          out_ins_d   = queue_q[head_q].ins;
          out_valid_d = 1'b1;
        end else begin
          out_ins_d   = NOP;
          out_valid_d = 1'b0;
        end
      end
    end
  end

  // Drain FSM: DRAIN while stale responses are still owed by the memory.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (stale_d != '0) state_d = DRAIN;
      DRAIN:   if (stale_d == '0) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= RUN;
      fetch_pc_q  <= RESET_PC;
      resp_pc_q   <= RESET_PC;
      count_q     <= '0;
      live_q      <= '0;
      stale_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      out_pc_q    <= '0;
      out_ins_q   <= NOP;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      resp_pc_q   <= resp_pc_d;
      count_q     <= count_d;
      live_q      <= live_d;
      stale_q     <= stale_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      out_pc_q    <= out_pc_d;
      out_ins_q   <= out_ins_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Queue storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; count/head/tail define which
    // entries are meaningful, so stale contents are never observed.
    if (push) queue_q[tail_q] <= '{pc: resp_pc_q, ins: bus.inRespData};
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue. A memory model answers accepted requests
// in order after a programmable latency and pushes the expected {pc, ins} pair
// into a scoreboard; a monitor pops and compares whenever decode sees a new
// valid pair. Directed checks cover reset, stall, backpressure, redirect and
// PC wrap-around.
module tb_fetch_queue;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_queue_if #(.BUS_DATA_WIDTH(64)) bus ();
  fetch_queue_if #(.BUS_DATA_WIDTH(64)) w_bus ();

  fetch_queue #(.BUS_DATA_WIDTH(64), .RESET_PC(64'h0), .QUEUE_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // Second instance only exercises fetch-address wrap-around.
  fetch_queue #(.BUS_DATA_WIDTH(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .QUEUE_DEPTH(4)) wdut (
    .clk(clk), .reset(reset), .bus(w_bus)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ins;
  } exp_t;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } pend_t;

  exp_t  exp_q [$];
  pend_t pend [$];
  int    cyc = 0;
  int    lat = 1;
  int    vectors = 0;
  int    miscompares = 0;

  function automatic logic [31:0] mem_word(input logic [63:0] addr);
    return addr[31:0] ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model and scoreboard producer.
  initial begin : env
    logic  s_acc, s_redir, s_rst;
    logic [63:0] s_addr;
    pend_t p;
    bus.inRespValid = 1'b0;
    bus.inRespData  = '0;
    forever begin
      @(negedge clk);
      s_acc   = bus.outReqValid && bus.inReqReady;
      s_addr  = bus.outReqAddr;
      s_redir = bus.inRedirect;
      s_rst   = reset;
      @(posedge clk);
      cyc++;
      #1;
      if (s_rst) begin
        pend.delete();
        exp_q.delete();
      end else begin
        if (s_redir) exp_q.delete();
        if (s_acc) begin
          pend.push_back('{addr: s_addr, due: cyc + lat - 1});
          exp_q.push_back('{pc: s_addr, ins: mem_word(s_addr)});
        end
      end
      if (!s_rst && pend.size() > 0 && pend[0].due <= cyc) begin
        p = pend.pop_front();
        bus.inRespValid = 1'b1;
        bus.inRespData  = mem_word(p.addr);
      end else begin
        bus.inRespValid = 1'b0;
        bus.inRespData  = '0;
      end
    end
  end

  // Scoreboard consumer: compares every new, held or bubble output.
  initial begin : mon
    logic stall_prev;
    exp_t last, e;
    stall_prev = 1'b0;
    last = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.outValid) begin
          if (stall_prev) begin
            check("held_pair", {bus.outPc[31:0], bus.outIns}, {last.pc[31:0], last.ins});
          end else if (exp_q.size() == 0) begin
            check("unexpected_valid", {bus.outPc[31:0], bus.outIns}, 64'hDEAD_DEAD_DEAD_DEAD);
          end else begin
            e = exp_q.pop_front();
            check("out_pc", bus.outPc, e.pc);
            check("out_ins", {32'h0, bus.outIns}, {32'h0, e.ins});
            last = e;
          end
        end else begin
          check("bubble_nop", {32'h0, bus.outIns}, {32'h0, NOP});
        end
        if (bus.inRespValid && !bus.inRedirect && dut.stale_q == '0 && dut.count_q == 3'd4) begin
          miscompares++;
          $display("FAIL queue_overflow: push into full queue (t=%0t)", $time);
        end
      end
      stall_prev = bus.inStall && !bus.inRedirect;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [63:0] a0;
    int          exp_stale;
    bit          found;

    reset = 1'b1;
    bus.inStall = 1'b0;  bus.inRedirect = 1'b0;  bus.inRedirectPc = '0;  bus.inReqReady = 1'b0;
    w_bus.inStall = 1'b0; w_bus.inRedirect = 1'b0; w_bus.inRedirectPc = '0; w_bus.inReqReady = 1'b1;
    w_bus.inRespValid = 1'b0; w_bus.inRespData = '0;
    lat = 1;
    tick(); tick();

    // Reset state.
    @(negedge clk);
    check("rst_out_valid", bus.outValid, 0);
    check("rst_out_ins", bus.outIns, NOP);
    check("rst_out_pc", bus.outPc, 0);
    check("rst_req_valid", bus.outReqValid, 0);
    check("rst_w_req_valid", w_bus.outReqValid, 0);

    // Streaming, 1-cycle memory latency, no stall.
    tick(); reset = 1'b0; bus.inReqReady = 1'b1;
    @(negedge clk);
    check("req_addr_0", bus.outReqAddr, 64'h0);
    check("req_valid_0", bus.outReqValid, 1);
    check("wrap_addr_first", w_bus.outReqAddr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    @(negedge clk);
    check("req_addr_4", bus.outReqAddr, 64'h4);
    check("wrap_addr_second", w_bus.outReqAddr, 64'h0);
    tick();
    // First response was presented last cycle and sits in the queue now;
    // the output register picks it up at the next edge.
    @(negedge clk);
    check("req_addr_8", bus.outReqAddr, 64'h8);
    check("out_valid_before", bus.outValid, 0);
    tick();
    @(negedge clk);
    check("out_valid_first", bus.outValid, 1);
    check("out_pc_first", bus.outPc, 64'h0);
    repeat (8) tick();

    // Stall for 6 cycles: credit fills the queue and requests stop.
    bus.inStall = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    check("stall_req_blocked", bus.outReqValid, 0);
    tick(); bus.inStall = 1'b0;
    repeat (8) tick();

    // Memory not ready for 5 cycles: address holds, queue runs dry.
    bus.inReqReady = 1'b0;
    @(negedge clk);
    a0 = bus.outReqAddr;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      check("notready_addr_stable", bus.outReqAddr, a0);
    end
    check("notready_out_valid", bus.outValid, 0);
    check("notready_out_ins", bus.outIns, NOP);

    // Redirect with two requests (0x10, 0x14) in flight.
    tick(); reset = 1'b1; tick(); tick();
    reset = 1'b0; lat = 4; bus.inRedirect = 1'b1; bus.inRedirectPc = 64'h10;
    tick(); bus.inRedirect = 1'b0; bus.inReqReady = 1'b1;
    @(negedge clk);
    check("redir_addr_10", bus.outReqAddr, 64'h10);
    tick();
    @(negedge clk);
    check("redir_addr_14", bus.outReqAddr, 64'h14);
    tick(); bus.inReqReady = 1'b0; bus.inRedirect = 1'b1; bus.inRedirectPc = 64'h100;
    @(negedge clk);
    check("redir_no_req", bus.outReqValid, 0);
    tick(); bus.inRedirect = 1'b0; bus.inReqReady = 1'b1; lat = 1;
    @(negedge clk);
    check("redir_stale_2", dut.stale_q, 2);
    check("redir_live_0", dut.live_q, 0);
    check("redir_addr_100", bus.outReqAddr, 64'h100);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.outValid) found = 1'b1;
      else @(negedge clk);
    end
    check("redir_out_seen", found, 1);
    check("redir_out_pc", bus.outPc, 64'h100);

    // Redirect together with stall and a response in the same cycle.
    repeat (5) tick();
    lat = 3;
    repeat (12) tick();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #2;
      if (bus.inRespValid) found = 1'b1;
    end
    check("rsr_resp_seen", found, 1);
    bus.inRedirect = 1'b1; bus.inStall = 1'b1; bus.inRedirectPc = 64'h200;
    @(negedge clk);
    exp_stale = pend.size();
    tick(); bus.inRedirect = 1'b0; bus.inStall = 1'b0;
    @(negedge clk);
    check("rsr_out_valid", bus.outValid, 0);
    check("rsr_out_ins", bus.outIns, NOP);
    check("rsr_stale", dut.stale_q, exp_stale);
    check("rsr_live", dut.live_q, 0);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (bus.outValid) found = 1'b1;
      else @(negedge clk);
    end
    check("rsr_out_seen", found, 1);
    check("rsr_out_pc", bus.outPc, 64'h200);

    // Final drain: every accepted request must have reached decode.
    repeat (10) tick();
    bus.inReqReady = 1'b0;
    repeat (30) tick();
    @(negedge clk);
    check("drain_scoreboard_empty", exp_q.size(), 0);
    check("drain_memory_idle", pend.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
